fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage of the 5-stage pipeline. It owns the PC register, drives the instruction-memory request, and produces the IF/ID pipeline latch (IF_ID_t) consumed by decode. It also applies redirects (branch, jump, jr) resolved in EX/MEM and freezes fetch on halt.

Parameters:
PC_INIT, 32'h0000_0000, PC value loaded on reset.

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
ihit  in  1  imem returned imemload for current imemaddr this cycle
imemload  in  32  instruction word (word_t)
imemREN  out  1  instruction read enable
imemaddr  out  32  instruction address (word_t)
stall  in  1  hazard unit: hold PC and IF/ID
redir_valid  in  1  EX/MEM redirect request
redir_pcsrc  in  3  pcsrc_t selecting redirect target
redir_baddr  in  32  branch target
redir_jaddr  in  32  j/jal target
redir_raddr  in  32  jr target (register value)
halt_in  in  1  halt reached MEM/WB
ifid  out  $bits(IF_ID_t)  IF/ID latch {imemload, pc, pc4}
ifid_valid  out  1  ifid holds a real fetched instruction

Behaviour:
- Reset (async, nRST=0): pc=PC_INIT; ifid={NOP,0,0}; ifid_valid=0; state=RUN. NOP=32'h0000_0000 (sll $0,$0,0).
- imemaddr=pc (combinational). imemREN=1 in RUN, 0 in HALT.
- pc4=pc+32'd4, modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
- Redirect decode: effective when redir_valid and redir_pcsrc in {PCSRC_REG, PCSRC_JAL, PCSRC_IMM}. Target: REG->redir_raddr, JAL->redir_jaddr, IMM->redir_baddr. Target bits [1:0] are forced to 0. PCSRC_NPC and PCSRC_CPC are never effective redirects.
- Priority per rising edge in RUN:
  1. stall=1: pc and ifid hold, regardless of ihit or redirect. EX/MEM is frozen, so the redirect stays presented.
  2. Effective redirect: pc<=target; ifid<=NOP bubble; ifid_valid<=0. This applies whether or not ihit is set, and the in-flight fetch is discarded.
  3. ihit=1: ifid<={imemload, pc, pc4}; ifid_valid<=1; pc<=pc4.
  4. ihit=0: pc holds; ifid<=bubble; ifid_valid<=0. This inserts one bubble per miss cycle.
- FSM:
  - RUN -> HALT when halt_in=1. This transition takes precedence over every row above.
  - Entering HALT: pc holds; ifid<=bubble; ifid_valid<=0.
  - HALT is absorbing until reset. In HALT, ihit, stall and redirect are all ignored.
- Latency: an instruction returned with ihit at edge N appears on ifid after edge N. One taken redirect costs its bubble cycle plus the refetch.
- Reset mid-miss or mid-stall: everything returns to reset values immediately and asynchronously. Fetch restarts from PC_INIT on the first edge after nRST rises.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds two outputs.
  - fetch_cnt (32): increments on each row-3 load.
  - bubble_cnt (32): increments on each row-2 or row-4 edge.
  - Both reset to 0, freeze in HALT, and wrap modulo 2^32.
- Undefined: these ports and counters do not exist. Behaviour is otherwise identical.

Decomposition:
- Shared package dp_types_pkg gains:
  - fetch_state_t enum {FETCH_RUN=1'b0, FETCH_HALT=1'b1}.
  - Constant NOP_INSTR=32'h0.
  - IF_ID_t is reused unchanged.
- One natural sub-module: pc_next_sel, the combinational pcsrc_t decode producing {redir_effective, aligned target, pc4}.

Test Plan:
1. Reset with PC_INIT=0, ihit=1 constantly, imemload=32'h2001_0005 -> after 3 edges: pc=0xC; ifid.pc=0x8, ifid.pc4=0xC; ifid_valid=1; imemREN=1.
2. ihit low for 2 cycles at pc=0x10 -> pc stays 0x10; ifid_valid=0 for 2 cycles. The next ihit loads ifid.pc=0x10.
3. redir_valid=1, pcsrc=PCSRC_IMM, baddr=0x0000_0102, ihit=1 -> pc=0x100; ifid=bubble; ifid_valid=0. Repeat with PCSRC_NPC -> no redirect, normal advance.
4. stall=1 with redir_valid(PCSRC_REG, raddr=0x40) for 3 cycles, then stall=0 -> pc and ifid unchanged for 3 edges, then pc=0x40 with a bubble.
5. halt_in=1 coinciding with ihit and an effective redirect -> HALT; pc frozen; imemREN=0; ifid_valid=0. Later stimulus is ignored until nRST pulse, after which pc=PC_INIT.
6. pc=0xFFFF_FFFC with ihit -> ifid.pc4=0x0; pc=0x0. With FETCH_PERF_CNT_EN defined, fetch_cnt increments by 1 per ihit load.

Source files
------------

// File: rtl/dp_types_pkg.sv
// Shared datapath types for the 5-stage pipeline: words, PC source select,
// IF/ID latch layout and fetch-stage state.
package dp_types_pkg;

  typedef logic [31:0] word_t;

  // PC source select carried down the pipe with a resolved control transfer.
  typedef enum logic [2:0] {
    PCSRC_NPC = 3'd0,
    PCSRC_CPC = 3'd1,
    PCSRC_REG = 3'd2,
    PCSRC_JAL = 3'd3,
    PCSRC_IMM = 3'd4
  } pcsrc_t;

  typedef struct packed {
    word_t imemload;
    word_t pc;
    word_t pc4;
  } IF_ID_t;

  typedef enum logic {
    FETCH_RUN  = 1'b0,
    FETCH_HALT = 1'b1
  } fetch_state_t;

  localparam word_t NOP_INSTR = 32'h0000_0000;

  // Empty IF/ID slot: a NOP with zeroed PC fields.
  function automatic IF_ID_t ifid_bubble();
    IF_ID_t b;
    b.imemload = NOP_INSTR;
    b.pc       = '0;
    b.pc4      = '0;
    return b;
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Decodes a resolved EX/MEM control transfer into an effective-redirect flag
// and a word-aligned target, and forms the sequential PC.
module pc_next_sel
  import dp_types_pkg::*;
(
  input  word_t  pc_i,
  input  logic   redir_valid_i,
  input  pcsrc_t redir_pcsrc_i,
  input  word_t  redir_baddr_i,
  input  word_t  redir_jaddr_i,
  input  word_t  redir_raddr_i,
  output logic   redir_effective_o,
  output word_t  target_o,
  output word_t  pc4_o
);

  word_t raw_target;

  // Select redirect source; NPC/CPC never redirect fetch.
  always_comb begin
    redir_effective_o = 1'b0;
    raw_target        = '0;
    case (redir_pcsrc_i)
      PCSRC_REG: begin
        redir_effective_o = redir_valid_i;
        raw_target        = redir_raddr_i;
      end
      PCSRC_JAL: begin
        redir_effective_o = redir_valid_i;
        raw_target        = redir_jaddr_i;
      end
      PCSRC_IMM: begin
        redir_effective_o = redir_valid_i;
        raw_target        = redir_baddr_i;
      end
      default: begin
        redir_effective_o = 1'b0;
        raw_target        = '0;
      end
    endcase
  end

  // Force word alignment on the target; sequential PC wraps mod 2^32.
  always_comb begin
    target_o = {raw_target[31:2], 2'b00};
    pc4_o    = pc_i + 32'd4;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives imem, fills the IF/ID latch,
// applies EX/MEM redirects and freezes on halt.
// Optional macro FETCH_PERF_CNT_EN adds fetch/bubble performance counters.
module fetch_stage
  import dp_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input  logic   CLK,
  input  logic   nRST,
  input  logic   ihit,
  input  word_t  imemload,
  output logic   imemREN,
  output word_t  imemaddr,
  input  logic   stall,
  input  logic   redir_valid,
  input  pcsrc_t redir_pcsrc,
  input  word_t  redir_baddr,
  input  word_t  redir_jaddr,
  input  word_t  redir_raddr,
  input  logic   halt_in,
  output IF_ID_t ifid,
  output logic   ifid_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output word_t  fetch_cnt,
  output word_t  bubble_cnt
`endif
);

  fetch_state_t state_q, state_d;
  word_t        pc_q, pc_d;
  IF_ID_t       ifid_q, ifid_d;
  logic         ifid_valid_q, ifid_valid_d;

  logic         redir_eff;
  word_t        redir_target;
  word_t        pc4;

  // Per-edge event flags, used by the optional counters.
  logic         ev_fetch;
  logic         ev_bubble;

  pc_next_sel u_pc_next_sel (
    .pc_i              (pc_q),
    .redir_valid_i     (redir_valid),
    .redir_pcsrc_i     (redir_pcsrc),
    .redir_baddr_i     (redir_baddr),
    .redir_jaddr_i     (redir_jaddr),
    .redir_raddr_i     (redir_raddr),
    .redir_effective_o (redir_eff),
    .target_o          (redir_target),
    .pc4_o             (pc4)
  );

  // Next state: halt beats stall beats redirect beats hit/miss.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_d       = ifid_q;
    ifid_valid_d = ifid_valid_q;
    ev_fetch     = 1'b0;
    ev_bubble    = 1'b0;
    unique case (state_q)
      FETCH_RUN: begin
        if (halt_in) begin
          state_d      = FETCH_HALT;
          ifid_d       = ifid_bubble();
          ifid_valid_d = 1'b0;
        end else if (stall) begin
          // Hold everything; the redirect stays presented by frozen EX/MEM.
        end else if (redir_eff) begin
          pc_d         = redir_target;
          ifid_d       = ifid_bubble();
          ifid_valid_d = 1'b0;
          ev_bubble    = 1'b1;
        end else if (ihit) begin
          ifid_d.imemload = imemload;
          ifid_d.pc       = pc_q;
          ifid_d.pc4      = pc4;
          ifid_valid_d    = 1'b1;
          pc_d            = pc4;
          ev_fetch        = 1'b1;
        end else begin
          ifid_d       = ifid_bubble();
          ifid_valid_d = 1'b0;
          ev_bubble    = 1'b1;
        end
      end
      FETCH_HALT: begin
        // Absorbing until reset.
      end
      default: begin
        state_d = FETCH_HALT;
      end
    endcase
  end

  // Fetch state registers with asynchronous reset.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= FETCH_RUN;
      pc_q         <= PC_INIT;
      ifid_q       <= ifid_bubble();
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_q       <= ifid_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  // Memory request and IF/ID outputs.
  always_comb begin
    imemaddr   = pc_q;
    imemREN    = (state_q == FETCH_RUN);
    ifid       = ifid_q;
    ifid_valid = ifid_valid_q;
  end

`ifdef FETCH_PERF_CNT_EN
  word_t fetch_cnt_q, fetch_cnt_d;
  word_t bubble_cnt_q, bubble_cnt_d;

  // Counters only move on RUN-state events, so they freeze in HALT.
  always_comb begin
    fetch_cnt_d  = fetch_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (ev_fetch) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
    if (ev_bubble) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  // Performance counter registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign fetch_cnt  = fetch_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a spec-level reference model checked
// on every falling edge, plus hand-computed literal expectations.
`timescale 1ns/1ps
module tb_fetch_stage;
  import dp_types_pkg::*;

  logic   CLK = 1'b0;
  logic   nRST = 1'b0;
  logic   ihit = 1'b0;
  word_t  imemload = '0;
  logic   imemREN;
  word_t  imemaddr;
  logic   stall = 1'b0;
  logic   redir_valid = 1'b0;
  pcsrc_t redir_pcsrc = PCSRC_NPC;
  word_t  redir_baddr = '0;
  word_t  redir_jaddr = '0;
  word_t  redir_raddr = '0;
  logic   halt_in = 1'b0;
  IF_ID_t ifid;
  logic   ifid_valid;
`ifdef FETCH_PERF_CNT_EN
  word_t  fetch_cnt;
  word_t  bubble_cnt;
`endif

  fetch_stage #(.PC_INIT(32'h0000_0000)) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .ihit        (ihit),
    .imemload    (imemload),
    .imemREN     (imemREN),
    .imemaddr    (imemaddr),
    .stall       (stall),
    .redir_valid (redir_valid),
    .redir_pcsrc (redir_pcsrc),
    .redir_baddr (redir_baddr),
    .redir_jaddr (redir_jaddr),
    .redir_raddr (redir_raddr),
    .halt_in     (halt_in),
    .ifid        (ifid),
    .ifid_valid  (ifid_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt   (fetch_cnt),
    .bubble_cnt  (bubble_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  int n_vec  = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  // Reference model state.
  word_t  m_pc;
  logic [95:0] m_ifid;
  logic   m_valid;
  logic   m_halt;
  word_t  m_fcnt;
  word_t  m_bcnt;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model, away from the rising edge.
  always @(negedge CLK) begin
    if (chk_en) begin
      chk("m_imemaddr", {64'h0, imemaddr}, {64'h0, m_pc});
      chk("m_imemREN", {95'h0, imemREN}, {95'h0, !m_halt});
      chk("m_ifid", ifid, m_ifid);
      chk("m_ifid_valid", {95'h0, ifid_valid}, {95'h0, m_valid});
`ifdef FETCH_PERF_CNT_EN
      chk("m_fetch_cnt", {64'h0, fetch_cnt}, {64'h0, m_fcnt});
      chk("m_bubble_cnt", {64'h0, bubble_cnt}, {64'h0, m_bcnt});
`endif
    end
  end

  function automatic logic redirect_taken(output word_t tgt);
    tgt = '0;
    if (!redir_valid) return 1'b0;
    if (redir_pcsrc == PCSRC_REG) tgt = redir_raddr;
    else if (redir_pcsrc == PCSRC_JAL) tgt = redir_jaddr;
    else if (redir_pcsrc == PCSRC_IMM) tgt = redir_baddr;
    else return 1'b0;
    tgt = tgt & 32'hFFFF_FFFC;
    return 1'b1;
  endfunction

  // One clock edge: predict from current inputs, then commit after the edge.
  task automatic cyc();
    word_t n_pc = m_pc;
    logic [95:0] n_ifid = m_ifid;
    logic n_valid = m_valid;
    logic n_halt = m_halt;
    word_t n_f = m_fcnt;
    word_t n_b = m_bcnt;
    word_t tgt;
    logic taken = redirect_taken(tgt);
    if (!m_halt) begin
      if (halt_in) begin
        n_halt = 1'b1; n_ifid = '0; n_valid = 1'b0;
      end else if (stall) begin
        n_pc = m_pc;
      end else if (taken) begin
        n_pc = tgt; n_ifid = '0; n_valid = 1'b0; n_b = m_bcnt + 1;
      end else if (ihit) begin
        n_ifid = {imemload, m_pc, m_pc + 32'd4};
        n_valid = 1'b1; n_pc = m_pc + 32'd4; n_f = m_fcnt + 1;
      end else begin
        n_ifid = '0; n_valid = 1'b0; n_b = m_bcnt + 1;
      end
    end
    @(posedge CLK);
    #1;
    m_pc = n_pc; m_ifid = n_ifid; m_valid = n_valid; m_halt = n_halt;
    m_fcnt = n_f; m_bcnt = n_b;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    #1;
    m_pc = 32'h0; m_ifid = '0; m_valid = 1'b0; m_halt = 1'b0;
    m_fcnt = '0; m_bcnt = '0;
    chk_en = 1'b1;
    chk("rst_async_pc", {64'h0, imemaddr}, 96'h0);
    chk("rst_async_valid", {95'h0, ifid_valid}, 96'h0);
    @(negedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  typedef struct {
    logic   ih;
    logic   st;
    logic   rv;
    pcsrc_t src;
    word_t  load;
  } vec_t;

  vec_t vtab[8];
  word_t fc0;

  initial begin
    vtab[0] = '{1'b1, 1'b0, 1'b0, PCSRC_NPC, 32'hAAAA_0001};
    vtab[1] = '{1'b0, 1'b0, 1'b1, PCSRC_CPC, 32'hAAAA_0002};
    vtab[2] = '{1'b1, 1'b1, 1'b0, PCSRC_NPC, 32'hAAAA_0003};
    vtab[3] = '{1'b1, 1'b0, 1'b1, PCSRC_JAL, 32'hAAAA_0004};
    vtab[4] = '{1'b1, 1'b0, 1'b0, PCSRC_NPC, 32'hAAAA_0005};
    vtab[5] = '{1'b0, 1'b0, 1'b1, PCSRC_REG, 32'hAAAA_0006};
    vtab[6] = '{1'b1, 1'b0, 1'b1, PCSRC_NPC, 32'hAAAA_0007};
    vtab[7] = '{1'b0, 1'b0, 1'b0, PCSRC_NPC, 32'hAAAA_0008};

    // 1: reset then three sequential hits.
    ihit = 1'b1;
    imemload = 32'h2001_0005;
    do_reset();
    chk("reset_ren", {95'h0, imemREN}, 96'h1);
    repeat (3) cyc();
    chk("t1_pc", {64'h0, imemaddr}, 96'hC);
    chk("t1_ifid_pc", {64'h0, ifid.pc}, 96'h8);
    chk("t1_ifid_pc4", {64'h0, ifid.pc4}, 96'hC);
    chk("t1_ifid_load", {64'h0, ifid.imemload}, 96'h2001_0005);
    chk("t1_valid", {95'h0, ifid_valid}, 96'h1);

    // 2: two miss cycles at 0x10.
    cyc();
    ihit = 1'b0;
    repeat (2) begin
      cyc();
      chk("t2_pc_hold", {64'h0, imemaddr}, 96'h10);
      chk("t2_bubble", {95'h0, ifid_valid}, 96'h0);
    end
    ihit = 1'b1;
    imemload = 32'h8C22_0004;
    cyc();
    chk("t2_refetch_pc", {64'h0, ifid.pc}, 96'h10);

    // 3: branch redirect with misaligned target, then a non-redirect pcsrc.
    redir_valid = 1'b1; redir_pcsrc = PCSRC_IMM; redir_baddr = 32'h0000_0102;
    cyc();
    chk("t3_target", {64'h0, imemaddr}, 96'h100);
    chk("t3_ifid_bubble", ifid, 96'h0);
    chk("t3_valid", {95'h0, ifid_valid}, 96'h0);
    redir_pcsrc = PCSRC_NPC;
    cyc();
    chk("t3_npc_pc", {64'h0, imemaddr}, 96'h104);
    chk("t3_npc_ifid", {64'h0, ifid.pc}, 96'h100);
    redir_pcsrc = PCSRC_CPC;
    cyc();

    // 4: stall holds even with a jr redirect presented.
    stall = 1'b1; redir_pcsrc = PCSRC_REG; redir_raddr = 32'h0000_0040;
    repeat (3) begin
      cyc();
      chk("t4_stall_pc", {64'h0, imemaddr}, 96'h108);
      chk("t4_stall_ifid", {64'h0, ifid.pc}, 96'h104);
    end
    stall = 1'b0;
    cyc();
    chk("t4_jr_pc", {64'h0, imemaddr}, 96'h40);
    chk("t4_jr_valid", {95'h0, ifid_valid}, 96'h0);

    // Mixed vector table, model-checked.
    redir_jaddr = 32'h0000_0203; redir_raddr = 32'h0000_0087;
    for (int i = 0; i < 8; i++) begin
      ihit = vtab[i].ih; stall = vtab[i].st; redir_valid = vtab[i].rv;
      redir_pcsrc = vtab[i].src; imemload = vtab[i].load;
      cyc();
    end
    stall = 1'b0;

    // 6: wrap of pc4 at the top of the address space.
    redir_valid = 1'b1; redir_pcsrc = PCSRC_JAL; redir_jaddr = 32'hFFFF_FFFF; ihit = 1'b1;
    cyc();
    chk("t6_top_pc", {64'h0, imemaddr}, 96'hFFFF_FFFC);
    redir_valid = 1'b0;
`ifdef FETCH_PERF_CNT_EN
    fc0 = fetch_cnt;
`endif
    cyc();
    chk("t6_wrap_pc4", {64'h0, ifid.pc4}, 96'h0);
    chk("t6_wrap_pc", {64'h0, imemaddr}, 96'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("t6_fetch_cnt_inc", {64'h0, fetch_cnt - fc0}, 96'h1);
`endif
    cyc();

    // 5: halt beats a simultaneous hit and redirect; then absorbing.
    halt_in = 1'b1; redir_valid = 1'b1; redir_pcsrc = PCSRC_IMM; redir_baddr = 32'h300;
    cyc();
    chk("t5_halt_pc", {64'h0, imemaddr}, 96'h4);
    chk("t5_halt_ren", {95'h0, imemREN}, 96'h0);
    chk("t5_halt_valid", {95'h0, ifid_valid}, 96'h0);
    halt_in = 1'b0;
    repeat (2) cyc();
    stall = 1'b1; cyc(); stall = 1'b0; ihit = 1'b0; cyc();
    chk("t5_still_halted", {64'h0, imemaddr}, 96'h4);
    redir_valid = 1'b0; ihit = 1'b1;
    do_reset();
    chk("t5_reset_pc", {64'h0, imemaddr}, 96'h0);
    chk("t5_reset_ren", {95'h0, imemREN}, 96'h1);
    repeat (2) cyc();

    // Reset in the middle of a miss.
    ihit = 1'b0;
    repeat (2) cyc();
    do_reset();
    ihit = 1'b1;
    cyc();
    chk("mid_miss_restart", {64'h0, ifid.pc}, 96'h0);
    cyc();

    @(negedge CLK);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
